// File: rtl/seg7_scan_capture.sv
// Receive side of the six-digit multiplexed 7-segment bus: settles, decodes and reassembles HH:MM:SS frames.
// Build option: define CAPTURE_DPT_EN to capture per-digit decimal points into dpt_mask.
module seg7_scan_capture #(
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] scan_sel,
    input  logic [6:0] scan_seg,
    input  logic       scan_dpt,
    output logic [3:0] digit5,
    output logic [3:0] digit4,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [5:0] dpt_mask,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       time_valid,
    output logic       seg_err,
    output logic       seq_err
);

    // state   | meaning
    // EXP_S5  | waiting for sel 5 (seconds units), start of a frame
    // EXP_S4  | seconds units held, waiting for sel 4
    // EXP_S3  | waiting for sel 3
    // EXP_S2  | waiting for sel 2
    // EXP_S1  | waiting for sel 1
    // EXP_S0  | waiting for sel 0; a match completes the frame
    typedef enum logic [2:0] {
        EXP_S0 = 3'd0,
        EXP_S1 = 3'd1,
        EXP_S2 = 3'd2,
        EXP_S3 = 3'd3,
        EXP_S4 = 3'd4,
        EXP_S5 = 3'd5
    } exp_t;

    if (SETTLE_CYC < 2 || SETTLE_CYC > 15) begin : g_settle_range
        $error("SETTLE_CYC must be within 2..15");
    end

`ifdef CAPTURE_DPT_EN
    localparam int IW = 11;
    logic [IW-1:0] in_d;
    assign in_d = {scan_sel, scan_seg, scan_dpt};
`else
    localparam int IW = 10;
    logic [IW-1:0] in_d;
    logic          unused_dpt;
    assign in_d       = {scan_sel, scan_seg};
    assign unused_dpt = scan_dpt;
`endif

    logic [IW-1:0] in_q;
    logic [IW-1:0] in_prev;
    logic [IW-1:0] cap_data;
    logic [3:0]    cnt;
    logic          changed;
    logic          cap;
    logic          cap_q;

    logic [2:0]    cap_sel;
    logic [6:0]    cap_seg;
    logic [3:0]    dec_digit;
    logic          dec_bad;

    exp_t          state_q;
    exp_t          state_d;
    logic          sh_we;
    logic [2:0]    sh_idx;
    logic          frame_load;
    logic          seq_err_d;

    logic [3:0]    sh_dig [5];

    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1111110: return 5'h00;
            7'b0110000: return 5'h01;
            7'b1101101: return 5'h02;
            7'b1111001: return 5'h03;
            7'b0110011: return 5'h04;
            7'b1011011: return 5'h05;
            7'b1011111: return 5'h06;
            7'b1110000: return 5'h07;
            7'b1111111: return 5'h08;
            7'b1111011: return 5'h09;
            default:    return 5'h1F;
        endcase
    endfunction

    function automatic logic time_legal(input logic [3:0] h1, input logic [3:0] h0,
                                        input logic [3:0] m1, input logic [3:0] m0,
                                        input logic [3:0] s1, input logic [3:0] s0);
        logic hrs_ok;
        hrs_ok = (h1 < 4'd2 && h0 <= 4'd9) || (h1 == 4'd2 && h0 <= 4'd3);
        return hrs_ok && (m1 <= 4'd5) && (m0 <= 4'd9) && (s1 <= 4'd5) && (s0 <= 4'd9);
    endfunction

    assign changed = (in_q != in_prev);
    // The counter reaches SETTLE_CYC-1 on the edge after it reads SETTLE_CYC-2 with the bus unchanged.
    assign cap     = !changed && (cnt == 4'(SETTLE_CYC - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q     <= '0;
            in_prev  <= '0;
            cnt      <= '0;
            cap_q    <= 1'b0;
            cap_data <= '0;
        end else begin
            in_q    <= in_d;
            in_prev <= in_q;
            cap_q   <= cap;
            if (changed) begin
                cnt <= '0;
            end else if (cnt != 4'(SETTLE_CYC)) begin
                cnt <= cnt + 4'd1;
            end
            if (cap) begin
                cap_data <= in_q;
            end
        end
    end

    assign cap_sel = cap_data[IW-1 -: 3];
    assign cap_seg = cap_data[IW-4 -: 7];
    assign {dec_bad, dec_digit} = seg_decode(cap_seg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EXP_S5;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_we      = 1'b0;
        sh_idx     = 3'd0;
        frame_load = 1'b0;
        seq_err_d  = 1'b0;
        if (cap_q) begin
            if (cap_sel > 3'd5) begin
                seq_err_d = 1'b1;
                state_d   = EXP_S5;
            end else if (cap_sel == state_q) begin
                sh_we  = 1'b1;
                sh_idx = 3'd5 - cap_sel;
                if (cap_sel == 3'd0) begin
                    frame_load = 1'b1;
                    state_d    = EXP_S5;
                end else begin
                    state_d = exp_t'(cap_sel - 3'd1);
                end
            end else begin
                seq_err_d = 1'b1;
                // A stray seconds-units digit is taken as the start of a fresh frame.
                if (cap_sel == 3'd5) begin
                    sh_we   = 1'b1;
                    sh_idx  = 3'd0;
                    state_d = EXP_S4;
                end else begin
                    state_d = EXP_S5;
                end
            end
        end
    end

    // Hours tens never lands in the shadow; it goes straight to digit5 on frame completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                sh_dig[i] <= '0;
            end
        end else if (sh_we && sh_idx < 3'd5) begin
            sh_dig[sh_idx] <= dec_digit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit5      <= '0;
            digit4      <= '0;
            digit3      <= '0;
            digit2      <= '0;
            digit1      <= '0;
            digit0      <= '0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            time_valid  <= 1'b0;
            seg_err     <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            frame_done <= frame_load;
            seg_err    <= cap_q && dec_bad;
            seq_err    <= seq_err_d;
            if (frame_load) begin
                digit5      <= dec_digit;
                digit4      <= sh_dig[4];
                digit3      <= sh_dig[3];
                digit2      <= sh_dig[2];
                digit1      <= sh_dig[1];
                digit0      <= sh_dig[0];
                frame_valid <= 1'b1;
                time_valid  <= time_legal(dec_digit, sh_dig[4], sh_dig[3],
                                          sh_dig[2], sh_dig[1], sh_dig[0]);
            end
        end
    end

`ifdef CAPTURE_DPT_EN
    logic       cap_dpt;
    logic [4:0] sh_dpt;

    assign cap_dpt = cap_data[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_dpt <= '0;
        end else if (sh_we && sh_idx < 3'd5) begin
            sh_dpt[sh_idx] <= cap_dpt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dpt_mask <= '0;
        end else if (frame_load) begin
            dpt_mask <= {cap_dpt, sh_dpt};
        end
    end
`else
    assign dpt_mask = 6'b000000;
`endif

endmodule
